serial_adder_sequencer: RTL
===========================

Name: serial_adder_sequencer

Overview:
- Bit-serial adder controller that reuses one half-adder pair plus a carry flop to add two WIDTH-bit operands, one bit per clock, LSB first.
- Sequences operand shifting, carry propagation and result capture, with a start/busy/done handshake.
- Sits inside the TinyTapeout user project. ui_in carries the operands; uo_out carries the result and status bits.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..8).
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable. Low freezes all state.
- start  input  1  request a new addition. Sampled on clk when ena=1.
- a_in  input  WIDTH  operand A, captured when start is accepted.
- b_in  input  WIDTH  operand B, captured when start is accepted.
- sum_out  output  WIDTH  registered result sum, held between operations.
- carry_out  output  1  registered carry-out of the last completed addition.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when sum_out/carry_out update.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - Shift registers, carry flop, bit counter, sum_out, carry_out, busy and done all 0.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- When ena=0, every register holds and start is ignored. Latency extends by the number of ena-low cycles.
- IDLE or DONE, start=1 (start is accepted):
  - Load a_sh<=a_in, b_sh<=b_in, c<=0, cnt<=0.
  - Go to RUN.
- DONE, no start: go to IDLE next edge, so done lasts exactly one cycle.
- IDLE, no start: stay in IDLE.
- RUN, each enabled edge:
  - s = a_sh[0]^b_sh[0]^c (two cascaded half adders).
  - c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
  - a_sh, b_sh shift right one bit.
  - s_sh <= {s, s_sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1:
  - sum_out <= {s, s_sh[WIDTH-1:1]} and carry_out <= carry computed this edge.
  - Go to DONE.
- start while in RUN is ignored and not queued. Operands captured at acceptance are unaffected by later a_in/b_in changes.
- Latency: start accepted at edge 0 gives WIDTH RUN cycles. sum_out, carry_out and done become valid after edge WIDTH. done is high for the cycle following edge WIDTH.
- Back-to-back: start held high in DONE restarts immediately.
  - Throughput is one result per WIDTH+1 cycles.
  - done still pulses for one cycle.
- sum_out and carry_out change only on the RUN→DONE edge or on reset. They are stable during the next operation's RUN.
- Overflow: results wrap modulo 2^WIDTH, with the overflow bit reported in carry_out.
- Reset mid-RUN: aborts the operation and clears everything to the reset state. No done pulse.
- rst_n deassertion is synchronised externally. After deassertion the block accepts start on the first enabled edge.

Test Plan:
- WIDTH=4, ena=1, start pulse with a=3, b=5 -> busy high 4 cycles, then done pulse; sum_out=8, carry_out=0.
- a=15, b=1 -> sum_out=0, carry_out=1. Then a=15, b=15 back-to-back (start held high through DONE) -> sum_out=14, carry_out=1, second done exactly 5 cycles after the first.
- start a=2, b=2, then start with a=7, b=7 pulsed at cycle 2 of RUN -> second start ignored; result 4/0; busy never reasserts without a new start.
- start a=9, b=6 with ena dropped for 3 cycles mid-RUN -> done arrives 7 cycles after start; sum_out=15, carry_out=0; counter and state frozen while ena=0.
- Complete 3+5, then start 10+7 and assert rst_n=0 at cycle 2 of RUN -> outputs immediately 0, state IDLE, no done. After release, 10+7 -> sum_out=1, carry_out=1.
- Exhaustive: all 256 (a,b) pairs with random ena gaps -> {carry_out,sum_out}==a+b for every done pulse, exactly one done per accepted start.

Source files
------------

// File: rtl/serial_adder_sequencer_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The master drives the request side; the slave (the adder) drives the results.
interface serial_adder_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             ena;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] sum_out;
   logic             carry_out;
   logic             busy;
   logic             done;

   modport master (
      output ena, start, a_in, b_in,
      input  sum_out, carry_out, busy, done
   );

   modport slave (
      input  ena, start, a_in, b_in,
      output sum_out, carry_out, busy, done
   );
endinterface

// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder: one full-add step per enabled clock, LSB first, with a
// start/busy/done handshake. Results are held until the next operation completes.
module serial_adder_sequencer #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_adder_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             w_ha_s;
   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic             w_accept;

   // Two cascaded half adders form the single full-add stage.
   assign w_ha_s   = r_a_sh[0] ^ r_b_sh[0];
   assign w_s      = w_ha_s ^ r_c;
   assign w_c      = (r_a_sh[0] & r_b_sh[0]) | (r_c & w_ha_s);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_accept = bus.start && (r_state != RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (bus.ena) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         DONE:    w_next = bus.start ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (r_state == RUN);
      bus.done      = (r_state == DONE);
      bus.sum_out   = r_sum;
      bus.carry_out = r_carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (bus.ena) begin
         if (w_accept) begin
            r_a_sh <= bus.a_in;
            r_b_sh <= bus.b_in;
            r_c    <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_s_sh <= {w_s, r_s_sh[WIDTH-1:1]};
            r_c    <= w_c;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum   <= {w_s, r_s_sh[WIDTH-1:1]};
               r_carry <= w_c;
            end
         end
      end
   end
endmodule
